// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Hazard and sequencing controller for the 5-stage RISC-V core. Decides,
// every cycle, which of the PC / IF/ID / ID/EX / back-end registers hold,
// flush or take a bubble, and sequences WFI sleep and MRET return.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mem_stall                IM/DM bus pending: freeze the whole pipeline
//   id_rs1, id_rs2           source registers of the ID instruction
//   id_use_rs1, id_use_rs2   ID instruction really reads rs1 / rs2
//   ex_rd, ex_memread        destination / load flag of the EX instruction
//   ex_branch_taken          taken branch or jump resolved in EX
//   id_wfi, id_mret          WFI / MRET decoded in ID
//   irq_pending              enabled interrupt pending
//   pc_stall, ifid_stall     hold PC / hold IF/ID
//   ifid_flush, idex_flush   NOP into IF/ID / bubble into ID/EX
//   pipe_freeze              hold ID/EX, EX/MEM, MEM/WB
//   wfi, mret_out            core asleep / MRET return in progress
//   trap_take, csr_mret      one-cycle pulses to the CSR unit
//   stall_cnt                saturating count of cycles with pc_stall=1
module hazard_ctrl #(
   parameter int unsigned MRET_CYC       = 2,
   parameter logic [31:0] STALL_CNT_INIT = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_stall,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_memread,
   input  logic        ex_branch_taken,
   input  logic        id_wfi,
   input  logic        id_mret,
   input  logic        irq_pending,
   output logic        pc_stall,
   output logic        ifid_stall,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        pipe_freeze,
   output logic        wfi,
   output logic        mret_out,
   output logic        trap_take,
   output logic        csr_mret,
   output logic [31:0] stall_cnt
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_SLEEP = 2'd1;
   localparam logic [1:0] ST_MRET  = 2'd2;

   // The MRET cycle itself counts as the first held cycle.
   localparam logic [3:0] MRET_LOAD = 4'(MRET_CYC - 1);

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic [3:0] mret_cnt;
   logic [3:0] mret_cnt_nxt;
   logic       lu;
   logic       ifid_stall_raw;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign lu = ex_memread && (ex_rd != 5'd0) &&
               (((ex_rd == id_rs1) && id_use_rs1) ||
                ((ex_rd == id_rs2) && id_use_rs2));

   // A flush wins over a stall of the same register.
   assign ifid_stall = ifid_stall_raw && !ifid_flush;

   // Decision stage: everything is gated off while rst is high.
   always_comb begin
      pc_stall       = 1'b0;
      ifid_stall_raw = 1'b0;
      ifid_flush     = 1'b0;
      idex_flush     = 1'b0;
      pipe_freeze    = 1'b0;
      wfi            = 1'b0;
      mret_out       = 1'b0;
      trap_take      = 1'b0;
      csr_mret       = 1'b0;
      state_nxt      = state;
      mret_cnt_nxt   = mret_cnt;
      if (!rst) begin
         case (state)
            ST_RUN: begin
               if (mem_stall) begin
                  pc_stall       = 1'b1;
                  ifid_stall_raw = 1'b1;
                  pipe_freeze    = 1'b1;
               end else if (irq_pending) begin
                  trap_take  = 1'b1;
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (ex_branch_taken) begin
                  // WFI/MRET sitting in ID is on the wrong path here.
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (id_mret) begin
                  pc_stall     = 1'b1;
                  idex_flush   = 1'b1;
                  mret_out     = 1'b1;
                  state_nxt    = ST_MRET;
                  mret_cnt_nxt = MRET_LOAD;
               end else if (id_wfi) begin
                  pc_stall   = 1'b1;
                  idex_flush = 1'b1;
                  state_nxt  = ST_SLEEP;
               end else if (lu) begin
                  pc_stall       = 1'b1;
                  ifid_stall_raw = 1'b1;
                  idex_flush     = 1'b1;
               end
            end
            ST_SLEEP: begin
               idex_flush = 1'b1;
               if (irq_pending && !mem_stall) begin
                  trap_take  = 1'b1;
                  ifid_flush = 1'b1;
                  state_nxt  = ST_RUN;
               end else begin
                  wfi            = 1'b1;
                  pc_stall       = 1'b1;
                  ifid_stall_raw = 1'b1;
                  pipe_freeze    = mem_stall;
               end
            end
            ST_MRET: begin
               idex_flush = 1'b1;
               if ((mret_cnt == 4'd0) && !mem_stall) begin
                  csr_mret   = 1'b1;
                  ifid_flush = 1'b1;
                  state_nxt  = ST_RUN;
               end else begin
                  mret_out       = 1'b1;
                  pc_stall       = 1'b1;
                  ifid_stall_raw = 1'b1;
                  pipe_freeze    = mem_stall;
                  if ((mret_cnt != 4'd0) && !mem_stall)
                     mret_cnt_nxt = mret_cnt - 4'd1;
               end
            end
            default: begin
               // Unused encoding: fall back to RUN.
               state_nxt    = ST_RUN;
               mret_cnt_nxt = 4'd0;
            end
         endcase
      end
   end

   // State stage: sequencing state and the stall counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         mret_cnt  <= 4'd0;
         stall_cnt <= STALL_CNT_INIT;
      end else begin
         state    <= state_nxt;
         mret_cnt <= mret_cnt_nxt;
         if (pc_stall)
            stall_cnt <= sat_inc(stall_cnt);
      end
   end

endmodule
